// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex display: the seven-segment
// glyph table (gfedcba, active-high) and the all-segments-off pattern.
package hex_disp_pkg;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b011_1111, 7'b000_0110, 7'b101_1011, 7'b100_1111,
        7'b110_0110, 7'b110_1101, 7'b111_1101, 7'b000_0111,
        7'b111_1111, 7'b110_1111, 7'b111_0111, 7'b111_1100,
        7'b011_1001, 7'b101_1110, 7'b111_1001, 7'b111_0001
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex nibble to seven-segment glyph (gfedcba, active-high).
module seg7_encode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for the scanned nibble
    always_comb begin
        seg = seg_lookup(nibble);
    end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: prescaled digit scan, frame-aligned
// double-buffered value updates, leading-zero blanking and registered outputs.
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iVALUE,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iBLANK_LZ,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oDIG,
    output logic                    oFRAME
);

    localparam int                    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0]      PRE_ONE  = PRE_W'(1);
    localparam logic [2:0]            IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_MASK  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_MASK = (DIG_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        presc_r;
    logic [2:0]              idx_r;
    logic [4*NUM_DIGITS-1:0] disp_value_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic [4*NUM_DIGITS-1:0] pend_value_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pend_flag_r;

    logic                    tick_s;
    logic                    boundary_s;
    logic [3:0]              nibble_s;
    logic                    dp_s;
    logic [2:0]              lead_s;
    logic                    blank_s;
    logic [NUM_DIGITS-1:0]   dig_s;
    logic [6:0]              seg_raw_s;
    logic [6:0]              seg_s;

    seg7_encode u_encode (
        .nibble (nibble_s),
        .seg    (seg_raw_s)
    );

    // Dwell tick and frame boundary (tick while the last digit is scanned)
    always_comb begin
        tick_s     = (presc_r == PRE_LAST);
        boundary_s = tick_s && (idx_r == IDX_LAST);
    end

    // Select the scanned digit and find the most significant nonzero nibble
    always_comb begin
        nibble_s = 4'h0;
        dp_s     = 1'b0;
        lead_s   = 3'd0;
        dig_s    = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nibble_s = (idx_r == 3'(k)) ? disp_value_r[4*k +: 4] : nibble_s;
            dp_s     = (idx_r == 3'(k)) ? disp_dp_r[k] : dp_s;
            lead_s   = (disp_value_r[4*k +: 4] != 4'h0) ? 3'(k) : lead_s;
            dig_s[k] = (idx_r == 3'(k));
        end
        // Digit 0 never blanks because lead_s is never below zero
        blank_s = iBLANK_LZ && (idx_r > lead_s);
        seg_s   = blank_s ? SEG_OFF : seg_raw_s;
    end

    // Prescaler and digit index
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            presc_r <= {PRE_W{1'b0}};
            idx_r   <= 3'd0;
        end else begin
            presc_r <= tick_s ? {PRE_W{1'b0}} : presc_r + PRE_ONE;
            if (tick_s) begin
                idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Pending/display double buffer; the display only changes on a frame boundary
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            disp_value_r <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_value_r <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_flag_r  <= 1'b0;
        end else if (boundary_s && iLOAD) begin
            disp_value_r <= iVALUE;
            disp_dp_r    <= iDP;
            pend_flag_r  <= 1'b0;
        end else if (boundary_s && pend_flag_r) begin
            disp_value_r <= pend_value_r;
            disp_dp_r    <= pend_dp_r;
            pend_flag_r  <= 1'b0;
        end else if (iLOAD) begin
            pend_value_r <= iVALUE;
            pend_dp_r    <= iDP;
            pend_flag_r  <= 1'b1;
        end else begin
            pend_flag_r  <= pend_flag_r;
        end
    end

    // Registered pins with polarity applied; oFRAME rises the cycle the index returns to 0
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oSEG   <= SEG_OFF ^ SEG_MASK;
            oDP    <= DP_MASK;
            oDIG   <= DIG_MASK;
            oFRAME <= 1'b0;
        end else begin
            oSEG   <= seg_s ^ SEG_MASK;
            oDP    <= dp_s ^ DP_MASK;
            oDIG   <= dig_s ^ DIG_MASK;
            oFRAME <= boundary_s;
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench: the stimulus pushes each frame's expected digit dwells,
// a monitor pops one entry whenever a new digit dwell appears on oDIG.
module tb_hex_scan_display;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;

    logic [6:0]  seg, seg_inv;
    logic        dp_out, dp_out_inv;
    logic [3:0]  dig, dig_inv;
    logic        frame, frame_inv;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hex_scan_display #(
        .NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iLOAD(load), .iVALUE(value), .iDP(dp),
        .iBLANK_LZ(blank_lz), .oSEG(seg), .oDP(dp_out), .oDIG(dig), .oFRAME(frame)
    );

    hex_scan_display #(
        .NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_inv (
        .iCLK(clk), .iRST_N(rst_n), .iLOAD(load), .iVALUE(value), .iDP(dp),
        .iBLANK_LZ(blank_lz), .oSEG(seg_inv), .oDP(dp_out_inv), .oDIG(dig_inv), .oFRAME(frame_inv)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dps);
        exp_t e;
        e.dig = 4'b0001; e.seg = s0; e.dp = dps[0]; exp_q.push_back(e);
        e.dig = 4'b0010; e.seg = s1; e.dp = dps[1]; exp_q.push_back(e);
        e.dig = 4'b0100; e.seg = s2; e.dp = dps[2]; exp_q.push_back(e);
        e.dig = 4'b1000; e.seg = s3; e.dp = dps[3]; exp_q.push_back(e);
    endtask

    // Returns one time unit after the edge that raised oFRAME
    task automatic sync_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            found = frame;
        end
        check("frame_sync", 32'(found), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // iLOAD is sampled on the (offset+1)-th edge from the call
    task automatic do_load(input int offset, input logic [15:0] v, input logic [3:0] d);
        repeat (offset) @(posedge clk);
        #1;
        load = 1'b1; value = v; dp = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic load_on_boundary(input logic [15:0] v, input logic [3:0] d);
        do_load(15, v, d);
        check("boundary_load_frame", 32'(frame), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_out", 32'({seg, dp_out, dig, frame}), 32'(12'h000));
        check("rst_out_inv", 32'({seg_inv, dp_out_inv, dig_inv, frame_inv}), 32'({7'h7F, 1'b1, 4'hF, 1'b0}));
        exp_q.delete();
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        rst_n = 1'b1;
    endtask

    // Monitor: one scoreboard pop per new digit dwell, plus timing and polarity checks
    initial begin
        logic [3:0] prev_dig;
        int         dwell_len;
        int         frame_gap;
        bit         frame_armed;
        exp_t       e;
        prev_dig = 4'b0000; dwell_len = 0; frame_gap = 0; frame_armed = 1'b0;
        forever begin
            @(negedge clk);
            check("inverted_outputs", 32'({seg_inv, dp_out_inv, dig_inv, frame_inv}),
                  32'({~seg, ~dp_out, ~dig, frame}));
            frame_gap++;
            if (dig == 4'b0000) begin
                prev_dig = 4'b0000; dwell_len = 0; frame_armed = 1'b0;
            end else begin
                if (dig != prev_dig) begin
                    if (prev_dig != 4'b0000) check("dwell_len", 32'(dwell_len), 32'd4);
                    if (exp_q.size() == 0) begin
                        check("unexpected_dwell", 32'(dig), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dig", 32'(dig), 32'(e.dig));
                        check("seg", 32'({dig, seg}), 32'({e.dig, e.seg}));
                        check("dp", 32'({dig, dp_out}), 32'({e.dig, e.dp}));
                    end
                    dwell_len = 1;
                    prev_dig  = dig;
                end else begin
                    dwell_len++;
                end
                if (frame) begin
                    check("frame_on_last_digit", 32'(dig), 32'(4'b1000));
                    if (frame_armed) check("frame_period", 32'(frame_gap), 32'd16);
                    frame_gap   = 0;
                    frame_armed = 1'b1;
                end
            end
        end
    end

    // Stimulus: each step pushes the frame now starting, then loads for the next one
    initial begin
        rst_n = 1'b0; load = 1'b0; value = 16'h0000; dp = 4'b0000; blank_lz = 1'b0;
        apply_reset(3);

        sync_frame();
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

        sync_frame();
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        do_load(5, 16'h1A2F, 4'b0001);

        sync_frame();
        push_frame(7'h71, 7'h5B, 7'h77, 7'h06, 4'b0001);
        do_load(2, 16'h0050, 4'b1000);

        sync_frame();
        blank_lz = 1'b1;
        push_frame(7'h3F, 7'h6D, 7'h00, 7'h00, 4'b1000);
        do_load(7, 16'h0000, 4'b0000);

        sync_frame();
        push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
        do_load(1, 16'h1111, 4'b0000);
        do_load(3, 16'h2222, 4'b0000);

        sync_frame();
        blank_lz = 1'b0;
        push_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000);
        load_on_boundary(16'hD4B9, 4'b0110);
        push_frame(7'h6F, 7'h7C, 7'h66, 7'h5E, 4'b0110);

        sync_frame();
        push_frame(7'h6F, 7'h7C, 7'h66, 7'h5E, 4'b0110);
        do_load(4, 16'h9999, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        apply_reset(1);

        sync_frame();
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        sync_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
